linear_interpolator: RTL and testbench

- Upsampling counterpart to the team's moving-average (decimating/smoothing) filter. Where that filter collapses N samples into one average, this block expands each input sample into L output samples.
- The L outputs are linearly interpolated between the previous and current input samples.
- Sits on the source side of the filter chain. Generates smooth, rate-multiplied streams for downstream averaging and for bench stimulus.
- Valid/ready handshake on both sides.

---
 rtl/linear_interpolator.sv | 137 +++++++++++++
 tb/tb_linear_interpolator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_interpolator.sv
// linear_interpolator: expands each input sample into L output samples that
// ramp linearly from the previous input to the current one.
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : synchronous clear of stored samples and any emission
//   in_data/in_valid/in_ready    : sample input handshake (in_ready is comb)
//   out_data/out_valid/out_ready : interpolated output handshake
//   out_last         : marks the phase L-1 sample of each group
module linear_interpolator #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned L          = 4,
   parameter int unsigned LOG2_L     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int unsigned SUM_W = DATA_WIDTH + LOG2_L + 1;
   localparam int unsigned WGT_W = LOG2_L + 1;

   localparam logic [1:0] ST_PRIME = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_EMIT  = 2'd2;

   localparam logic [LOG2_L-1:0] PHASE_LAST = LOG2_L'(L - 1);

   // Reject inconsistent L / LOG2_L at elaboration.
   generate
      if ((L < 2) || (L != (32'd1 << LOG2_L))) begin : g_bad_l
         $error("linear_interpolator: L must be a power of two >= 2 equal to 2**LOG2_L");
      end
   endgenerate

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] prev_q, prev_d;
   logic [DATA_WIDTH-1:0] cur_q, cur_d;
   logic [LOG2_L-1:0]     phase_q, phase_d;

   logic                  emit;
   logic                  at_last;
   logic                  in_xfer;
   logic                  out_xfer;
   logic [WGT_W-1:0]      wgt_cur;
   logic [WGT_W-1:0]      wgt_prev;
   logic [SUM_W-1:0]      wsum;

   assign emit    = (state_q == ST_EMIT);
   assign at_last = (phase_q == PHASE_LAST);

   // Accept a new sample whenever idle, or on the final beat of a group.
   assign in_ready = !emit || (at_last && out_ready);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = emit && out_ready;

   // Weighted sum is always non-negative and bounded by (2**DATA_WIDTH-1)*L.
   always_comb begin
      wgt_cur  = WGT_W'(phase_q);
      wgt_prev = WGT_W'(L) - wgt_cur;
      wsum     = SUM_W'(prev_q) * SUM_W'(wgt_prev) + SUM_W'(cur_q) * SUM_W'(wgt_cur);
   end

   assign out_valid = emit;
   assign out_last  = emit && at_last;
   assign out_data  = emit ? DATA_WIDTH'(wsum >> LOG2_L) : '0;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      cur_d   = cur_q;
      phase_d = phase_q;
      if (flush) begin
         state_d = ST_PRIME;
         phase_d = '0;
         prev_d  = '0;
         cur_d   = '0;
      end else begin
         case (state_q)
            ST_PRIME: begin
               if (in_xfer) begin
                  cur_d   = in_data;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (in_xfer) begin
                  prev_d  = cur_q;
                  cur_d   = in_data;
                  phase_d = '0;
                  state_d = ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_xfer) begin
                  if (!at_last) begin
                     phase_d = phase_q + LOG2_L'(1);
                  end else if (in_xfer) begin
                     // Start the next group with no idle cycle.
                     prev_d  = cur_q;
                     cur_d   = in_data;
                     phase_d = '0;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end
            end
            default: begin
               state_d = ST_PRIME;
               phase_d = '0;
            end
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PRIME;
         prev_q  <= '0;
         cur_q   <= '0;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cur_q   <= cur_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: tb/tb_linear_interpolator.sv
// Self-checking bench for linear_interpolator with a queue-based reference model.
module tb_linear_interpolator;

   localparam int LL = 4;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   linear_interpolator #(.DATA_WIDTH(8), .L(4), .LOG2_L(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int data;
      bit last;
   } exp_t;

   exp_t q[$];
   int   got[$];
   int   got_cyc[$];
   int   exp_q[$];
   int   cur_m;
   bit   have_m;
   int   cyc;
   int   checks;
   int   failures;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int interp(input int p, input int c, input int k);
      return (p * (LL - k) + c * k) / LL;
   endfunction

   // Reference model and per-cycle comparison, sampled mid-cycle.
   initial begin
      q.delete();
      have_m = 1'b0;
      cur_m  = 0;
      cyc    = 0;
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         q.delete();
         have_m = 1'b0;
      end else begin
         check("out_valid", int'(out_valid), int'(q.size() != 0));
         if (out_valid && q.size() != 0) begin
            check("out_data", int'(out_data), q[0].data);
            check("out_last", int'(out_last), int'(q[0].last));
         end
         check("in_ready", int'(in_ready), int'((q.size() == 0) || (q.size() == 1 && out_ready)));
         if (flush) begin
            q.delete();
            have_m = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               got.push_back(int'(out_data));
               got_cyc.push_back(cyc);
               if (q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
               if (have_m) begin
                  for (int k = 0; k < LL; k++) begin
                     exp_t e;
                     e.data = interp(cur_m, int'(in_data), k);
                     e.last = (k == LL - 1);
                     q.push_back(e);
                  end
               end
               cur_m  = int'(in_data);
               have_m = 1'b1;
            end
         end
      end
   end

   task automatic push(input logic [7:0] d);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) check("push_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic check_got(input string tag);
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check({tag, "_sample"}, got[i], exp_q[i]);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_data   = 8'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_in_ready", int'(in_ready), 1);
      #21 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1/2: first group, then back-to-back second group.
      got.delete(); got_cyc.delete();
      push(8'd10);
      idle(4);
      check("t1_no_out_after_first", got.size(), 0);
      check("t1_idle_valid", int'(out_valid), 0);
      push(8'd20);
      push(8'd30);
      idle(8);
      exp_q = '{10, 12, 15, 17, 20, 22, 25, 27};
      check_got("t12");
      if (got_cyc.size() >= 5) check("t2_no_bubble", got_cyc[4] - got_cyc[3], 1);
      else check("t2_no_bubble_len", got_cyc.size(), 5);

      // 3: constant input, then the 255 -> 0 downward boundary.
      flush_pulse();
      got.delete(); got_cyc.delete();
      push(8'd40); push(8'd40); push(8'd40); push(8'd255); push(8'd0);
      idle(8);
      exp_q = '{40, 40, 40, 40, 40, 40, 40, 40, 40, 93, 147, 201, 255, 191, 127, 63};
      check_got("t3");

      // 4: backpressure while the next input is held pending.
      flush_pulse();
      got.delete(); got_cyc.delete();
      push(8'd100);
      push(8'd200);
      fork
         begin
            bit pat[12];
            pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 12; i++) begin
               out_ready = pat[i];
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
         push(8'd60);
      join
      idle(8);
      exp_q = '{100, 125, 150, 175, 200, 165, 130, 95};
      check_got("t4");

      // 5: flush at phase 2 drops the group.
      flush_pulse();
      got.delete(); got_cyc.delete();
      push(8'd10);
      push(8'd20);
      idle(2);
      flush_pulse();
      check("t5_valid_drop", int'(out_valid), 0);
      push(8'd50);
      push(8'd60);
      idle(8);
      exp_q = '{10, 12, 50, 52, 55, 57};
      check_got("t5");

      // 6: asynchronous reset between edges mid-emission.
      got.delete(); got_cyc.delete();
      push(8'd70);
      push(8'd80);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", int'(out_valid), 0);
      check("t6_async_data", int'(out_data), 0);
      check("t6_async_in_ready", int'(in_ready), 1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      got.delete(); got_cyc.delete();
      push(8'd90);
      idle(5);
      check("t6_one_input_no_out", got.size(), 0);
      push(8'd100);
      idle(8);
      exp_q = '{90, 92, 95, 97};
      check_got("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
